// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter between NUM_REQ byte sources and times each frame slot.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BAUD_DIV   = 10416,
    parameter int FRAME_BITS = 10,
    parameter int GUARD_BITS = 2
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [2:0]           gnt_id,
    output logic                 transmit,
    output logic [7:0]           data,
    output logic                 tx_busy
);

    // Trigger is held past one full bit period so the transmitter's bit tick always sees it.
    localparam int HOLD_CYC = BAUD_DIV + 2;
    localparam int SLOT_CYC = HOLD_CYC + (FRAME_BITS + GUARD_BITS) * BAUD_DIV;
    localparam int CNT_W    = $clog2(SLOT_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(SLOT_CYC);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [2:0]         r_gnt_id;
    logic               r_transmit;
    logic [7:0]         r_data;
    logic               r_busy;

    logic               w_found;
    logic [2:0]         w_win;
    logic [2:0]         w_base;
    logic [7:0]         w_byte;
    logic [NUM_REQ-1:0] w_onehot;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign w_base = 3'd0;
`else
    logic [2:0] r_rr_ptr;
    assign w_base = r_rr_ptr;
`endif

    // First pass looks at indices at or above the pointer, second pass wraps to the lowest.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[k] && (3'(k) >= w_base)) begin
                w_found = 1'b1;
                w_win   = 3'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_win   = 3'(k);
            end
        end
    end

    always_comb begin
        w_byte   = 8'h00;
        w_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == 3'(k)) begin
                w_byte      = req_data[8*k +: 8];
                w_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found)            w_next = HOLD;
            HOLD:    if (r_cnt == HOLD_END)  w_next = WAIT;
            WAIT:    if (r_cnt == SLOT_END)  w_next = IDLE;
            default:                         w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_gnt_id   <= 3'd0;
            r_transmit <= 1'b0;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            r_rr_ptr   <= 3'd0;
`endif
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_data     <= w_byte;
                        r_gnt      <= w_onehot;
                        r_gnt_id   <= w_win;
                        r_transmit <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= CNT_W'(1);
`ifndef UART_ARB_FIXED_PRIO_EN
                        r_rr_ptr   <= (w_win == LAST_IDX) ? 3'd0 : w_win + 3'd1;
`endif
                    end
                end
                HOLD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == HOLD_END) r_transmit <= 1'b0;
                end
                WAIT: begin
                    if (r_cnt == SLOT_END) begin
                        r_busy <= 1'b0;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_id   = r_gnt_id;
    assign transmit = r_transmit;
    assign data     = r_data;
    assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter with BAUD_DIV=4 (slot of 54 cycles).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int BAUD_DIV = 4;
    localparam int HOLD_CYC = 6;
    localparam int SLOT_CYC = 54;

    logic        Clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [2:0]  gnt_id;
    logic        transmit;
    logic [7:0]  data;
    logic        tx_busy;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .BAUD_DIV(BAUD_DIV), .FRAME_BITS(10), .GUARD_BITS(2)
    ) dut (
        .Clock(Clock), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .gnt_id(gnt_id), .transmit(transmit), .data(data), .tx_busy(tx_busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int last_gnt_cyc = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] dword;
        int          exp_id;
        int          exp_id_fp;
        int          gap;
        bit          drop;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_gnt();
        int ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clock);
            if (gnt != 4'b0) begin
                ok = 1;
                break;
            end
        end
        chk("gnt_arrives", 32'(ok), 32'd1);
    endtask

    // Entered on the negedge where gnt is visible; leaves on the first negedge with tx_busy low.
    task automatic observe_slot(input int late_idx);
        int n_tx, n_busy, n_gnt, n_tx_late;
        n_tx = 0; n_busy = 0; n_gnt = 0; n_tx_late = 0;
        for (int k = 0; k < 120; k++) begin
            if (transmit) n_tx++;
            if (transmit && k >= HOLD_CYC) n_tx_late++;
            if (gnt != 4'b0) n_gnt++;
            if (!tx_busy) break;
            n_busy++;
            if (k == late_idx) req = 4'b0001;
            @(negedge Clock);
        end
        chk("slot_transmit_cycles", 32'(n_tx), 32'(HOLD_CYC));
        chk("slot_transmit_outside_hold", 32'(n_tx_late), 32'd0);
        chk("slot_busy_cycles", 32'(n_busy), 32'(SLOT_CYC));
        chk("slot_gnt_pulses", 32'(n_gnt), 32'd1);
    endtask

    initial begin
        int          eid;
        int          ok;
        logic [31:0] dw;

        vecs[0]  = '{4'b1111, 32'h44332211,  1, 0, 55, 1'b0};
        vecs[1]  = '{4'b1111, 32'h44332211,  2, 0, 55, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211,  3, 0, 55, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211,  0, 0, 55, 1'b0};
        vecs[4]  = '{4'b0100, 32'h44A52211,  2, 2, 55, 1'b1};
        vecs[5]  = '{4'b0000, 32'h44332211, -1, -1, 0, 1'b0};
        vecs[6]  = '{4'b0011, 32'h44332211,  0, 0,  0, 1'b0};
        vecs[7]  = '{4'b0011, 32'h44332211,  1, 0, 55, 1'b0};
        vecs[8]  = '{4'b0011, 32'h44332211,  0, 0, 55, 1'b0};
        vecs[9]  = '{4'b1001, 32'h44332211,  3, 0, 55, 1'b0};
        vecs[10] = '{4'b1001, 32'h44332211,  0, 0, 55, 1'b1};

        reset    = 1'b1;
        req      = 4'b1111;
        req_data = 32'h44332211;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            chk("reset_gnt", 32'(gnt), 32'd0);
            chk("reset_transmit", 32'(transmit), 32'd0);
            chk("reset_busy", 32'(tx_busy), 32'd0);
        end
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);

        reset = 1'b0;
        @(negedge Clock);
        chk("release_gnt", 32'(gnt), 32'b0001);
        chk("release_data", 32'(data), 32'h11);
        chk("release_transmit", 32'(transmit), 32'd1);
        chk("release_busy", 32'(tx_busy), 32'd1);
        last_gnt_cyc = cyc;
        observe_slot(-1);

        for (int i = 0; i < 11; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].dword;
`ifdef UART_ARB_FIXED_PRIO_EN
            eid = vecs[i].exp_id_fp;
`else
            eid = vecs[i].exp_id;
`endif
            if (eid < 0) begin
                ok = 1;
                for (int k = 0; k < 70; k++) begin
                    @(negedge Clock);
                    if (gnt != 4'b0 || tx_busy) ok = 0;
                end
                chk("idle_no_gnt", 32'(ok), 32'd1);
            end else begin
                wait_gnt();
                dw = vecs[i].dword;
                chk("vec_gnt", 32'(gnt), 32'(4'b0001 << eid));
                chk("vec_gnt_id", 32'(gnt_id), 32'(eid));
                chk("vec_data", 32'(data), 32'(dw[8*eid +: 8]));
                if (vecs[i].gap > 0) chk("vec_gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(vecs[i].gap));
                last_gnt_cyc = cyc;
                if (vecs[i].drop) req = 4'b0000;
                observe_slot(-1);
            end
        end

        // Late request: source 0 raises req partway through source 3's slot.
        req = 4'b1000;
        req_data = 32'h44332211;
        wait_gnt();
        chk("late_first_gnt", 32'(gnt), 32'b1000);
        last_gnt_cyc = cyc;
        req = 4'b0000;
        observe_slot(20);
        chk("late_not_early", 32'(gnt), 32'd0);
        @(negedge Clock);
        chk("late_gnt", 32'(gnt), 32'b0001);
        chk("late_data", 32'(data), 32'h11);
        chk("late_spacing", 32'(cyc - last_gnt_cyc), 32'(SLOT_CYC + 1));
        req = 4'b0000;

        // Reset in the middle of the slot that just started.
        for (int k = 0; k < 19; k++) @(negedge Clock);
        chk("midslot_busy_before_reset", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge Clock);
        chk("midslot_reset_transmit", 32'(transmit), 32'd0);
        chk("midslot_reset_busy", 32'(tx_busy), 32'd0);
        chk("midslot_reset_gnt", 32'(gnt), 32'd0);
        chk("midslot_reset_data", 32'(data), 32'd0);
        chk("midslot_reset_gnt_id", 32'(gnt_id), 32'd0);
        reset = 1'b0;
        req = 4'b1001;
        @(negedge Clock);
        chk("post_reset_gnt", 32'(gnt), 32'b0001);
        chk("post_reset_gnt_id", 32'(gnt_id), 32'd0);
        req = 4'b0000;
        observe_slot(-1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
